// File: rtl/keyed_gpr_file.sv
// General-purpose register file for the RV64 decode stage.
// The write index goes through a keyed lookup table that decodes rd into a
// one-hot select. Storage is one enable register per entry. x0 is never
// written, so it keeps its reset value of zero. Both read ports are
// combinational.

// Generic keyed multiplexer.
// The LUT is NR_KEY {key, data} pairs. Pair 0 sits in the most-significant bits.
// The output is the OR of every entry whose key matches, so no match gives zero.
module keyed_mux #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [PAIR_LEN-1:0] pair;

    // Scan all pairs and OR together the data of matching keys.
    always_comb begin
        out  = '0;
        pair = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            pair = lut[(NR_KEY-i)*PAIR_LEN-1 -: PAIR_LEN];
            if (pair[PAIR_LEN-1 -: KEY_LEN] == key) begin
                out = out | pair[DATA_LEN-1:0];
            end
        end
    end
endmodule

// Enable register with synchronous reset. There is no bypass: q is always
// the stored value.
module gpr_cell #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Reset wins over the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module keyed_gpr_file #(
    parameter int               XLEN      = 64,
    parameter int               NR_REG    = 32,
    parameter int               REG_SEL   = 5,
    parameter logic [XLEN-1:0]  RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [REG_SEL-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic [REG_SEL-1:0] raddr1,
    input  logic [REG_SEL-1:0] raddr2,
    output logic [XLEN-1:0]    rdata1,
    output logic [XLEN-1:0]    rdata2,
    output logic [NR_REG-1:0]  wsel
);
    localparam int PAIR_LEN = REG_SEL + NR_REG;

    logic [NR_REG*PAIR_LEN-1:0] dec_lut;
    logic [XLEN-1:0]            regs [NR_REG];

    // Decoder table: entry k maps key k to a one-hot select with bit k set.
    for (genvar k = 0; k < NR_REG; k++) begin : g_lut
        localparam logic [REG_SEL-1:0] KEY    = REG_SEL'(k);
        localparam logic [NR_REG-1:0]  ONEHOT = NR_REG'(1) << k;
        assign dec_lut[(NR_REG-k)*PAIR_LEN-1 -: PAIR_LEN] = {KEY, ONEHOT};
    end

    keyed_mux #(
        .NR_KEY  (NR_REG),
        .KEY_LEN (REG_SEL),
        .DATA_LEN(NR_REG)
    ) u_wdec (
        .key(waddr),
        .lut(dec_lut),
        .out(wsel)
    );

    // Cell 0 has its enable tied low, so x0 keeps RESET_VAL (zero).
    for (genvar i = 0; i < NR_REG; i++) begin : g_reg
        logic cell_en;
        if (i == 0) begin : g_x0
            assign cell_en = 1'b0;
        end else begin : g_xn
            assign cell_en = wen & wsel[i];
        end

        gpr_cell #(
            .WIDTH    (XLEN),
            .RESET_VAL(RESET_VAL)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .en (cell_en),
            .d  (wdata),
            .q  (regs[i])
        );
    end

    // Combinational read ports. A write in this cycle is not forwarded.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end
endmodule

// File: tb/tb_keyed_gpr_file.sv
// Self-checking bench for keyed_gpr_file. A plain array of 32 registers is the
// reference model. Directed cases come first, then a randomized mix of
// writes, reads and occasional resets.
module tb_keyed_gpr_file;
    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic [31:0] wsel;

    logic [63:0] model [32];
    int checks;
    int failures;

    keyed_gpr_file dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .wsel  (wsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge. The model applies the register file rules to the
    // inputs that were present at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (wen && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    // Read every index on both ports, one per cycle, with writes disabled.
    task automatic read_sweep(input string tag);
        wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            chk({tag, "_rd1"}, rdata1, model[i]);
            chk({tag, "_rd2"}, rdata2, model[31 - i]);
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        rst = 1'b1; wen = 1'b0; waddr = 5'd0; wdata = '0; raddr1 = '0; raddr2 = '0;

        // Reset for two edges, then every register must read zero.
        tick();
        tick();
        rst = 1'b0;
        read_sweep("reset");
        waddr = 5'd5;
        #1;
        chk("wsel_5", 64'(wsel), 64'h0000_0020);

        // Basic write and read.
        wen = 1'b1; waddr = 5'd3; wdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        wen = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4;
        #1;
        chk("basic_x3", rdata1, 64'hDEAD_BEEF_0123_4567);
        chk("basic_x4", rdata2, 64'h0);

        // A write to x0 is discarded, but its select bit is still decoded.
        wen = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wsel_0", 64'(wsel), 64'h0000_0001);
        tick();
        wen = 1'b0; raddr1 = 5'd0;
        #1;
        chk("x0_zero", rdata1, 64'h0);

        // With wen low, the register does not change.
        wen = 1'b0; waddr = 5'd7; wdata = 64'h55;
        tick();
        raddr1 = 5'd7;
        #1;
        chk("wen0_x7", rdata1, 64'h0);
        // Read during write: the old value before the edge, the new value after it.
        wen = 1'b1; wdata = 64'hAA;
        #1;
        chk("rdw_before", rdata1, 64'h0);
        tick();
        wen = 1'b0;
        chk("rdw_after", rdata1, 64'hAA);

        // Write every index from 1 to 31, then read them all back.
        for (int i = 1; i < 32; i++) begin
            wen = 1'b1; waddr = 5'(i); wdata = 64'(i) * 64'h0101_0101_0101_0101;
            #1;
            chk("sweep_wsel", 64'(wsel), 64'(64'h1 << i));
            tick();
        end
        read_sweep("sweep");
        chk("sweep_x31", model[31], 64'd31 * 64'h0101_0101_0101_0101);
        waddr = 5'd31;
        #1;
        chk("wsel_31", 64'(wsel), 64'h8000_0000);

        // Reset takes priority over a write at the same edge.
        wen = 1'b1; waddr = 5'd9; wdata = 64'h1234;
        tick();
        raddr1 = 5'd9; wen = 1'b0;
        #1;
        chk("x9_pre", rdata1, 64'h1234);
        rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 64'h9999;
        tick();
        rst = 1'b0; wen = 1'b0;
        chk("x9_collide", rdata1, 64'h0);
        read_sweep("collide");

        // Randomized mix of writes and resets, with reads checked against the model.
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 39) == 0);
            wen    = $urandom_range(0, 1);
            waddr  = 5'($urandom_range(0, 31));
            wdata  = {$urandom, $urandom};
            raddr1 = 5'($urandom_range(0, 31));
            raddr2 = (n % 4 == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            chk("rnd_rd1", rdata1, model[raddr1]);
            chk("rnd_rd2", rdata2, model[raddr2]);
            chk("rnd_wsel", 64'(wsel), 64'(64'h1 << waddr));
            tick();
        end
        rst = 1'b0; wen = 1'b0;
        read_sweep("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
